// File: rtl/numarator_pkg.sv
// Shared direction and mode encodings for the numarator counter family.
// Constants only; no logic and no latency.
package numarator_pkg;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/numarator_next.sv
// Combinational next-count and wrap/clamp event logic for one enabled step.
// Zero latency; no flow control, the caller decides when the result is taken.
module numarator_next
  import numarator_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 2**WIDTH,
  parameter int STEP_W  = 3
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic              up_down,
  input  logic              sat,
  output logic [WIDTH-1:0]  nxt,
  output logic              evt
);

  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] step_x;
  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] sum_x;

  always_comb begin
    step_x = (WIDTH+1)'(step);
    // An oversized step behaves like the largest legal one.
    if (step_x >= MOD_X) begin
      step_x = TOP_X;
    end
    cur_x = {1'b0, cur};
    sum_x = cur_x + step_x;
    nxt   = cur;
    evt   = 1'b0;
    if (up_down == DIR_UP) begin
      if (sum_x >= MOD_X) begin
        evt = 1'b1;
        nxt = (sat == MODE_SAT) ? TOP : WIDTH'(sum_x - MOD_X);
      end else begin
        nxt = WIDTH'(sum_x);
      end
    end else begin
      if (cur_x >= step_x) begin
        nxt = WIDTH'(cur_x - step_x);
      end else begin
        evt = 1'b1;
        nxt = (sat == MODE_SAT) ? '0 : WIDTH'(cur_x + MOD_X - step_x);
      end
    end
  end

endmodule

// File: rtl/numarator_univ.sv
// Modulo-N up/down counter with step, wrap/saturate, tc pulse and sticky ovf.
// One edge from inputs to out/tc/ovf; zero/max follow out; no backpressure, every edge is taken.
module numarator_univ
  import numarator_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 2**WIDTH,
  parameter int STEP_W  = 3
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic              UpDown,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  in,
  input  logic              clr_flag,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              ovf,
  output logic              zero,
  output logic              max
);

  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] nxt;
  logic             evt;
  logic             ovf_set;

  numarator_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS),
    .STEP_W (STEP_W)
  ) u_next (
    .cur    (out_q),
    .step   (step),
    .up_down(UpDown),
    .sat    (sat),
    .nxt    (nxt),
    .evt    (evt)
  );

  always_comb begin
    out_d   = out_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    if (load) begin
      if ({1'b0, in} >= MOD_X) begin
        out_d   = TOP;
        ovf_set = 1'b1;
      end else begin
        out_d = in;
      end
    end else if (en) begin
      out_d   = nxt;
      tc_d    = evt;
      ovf_set = evt;
    end
    // A new overflow outranks a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~clr_flag);
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
  assign zero = (out_q == '0);
  assign max  = (out_q == TOP);

endmodule

// File: tb/tb_numarator_univ.sv
// Directed vector bench for numarator_univ at WIDTH=5, MODULUS=24, STEP_W=3.
module tb_numarator_univ;

  logic       ck, reset, load, en, UpDown, sat, clr_flag;
  logic [2:0] step;
  logic [4:0] in;
  logic [4:0] out;
  logic       tc, ovf, zero, max;

  int nvec = 0;
  int nerr = 0;

  numarator_univ #(.WIDTH(5), .MODULUS(24), .STEP_W(3)) dut (
    .ck      (ck),
    .reset   (reset),
    .load    (load),
    .en      (en),
    .UpDown  (UpDown),
    .sat     (sat),
    .step    (step),
    .in      (in),
    .clr_flag(clr_flag),
    .out     (out),
    .tc      (tc),
    .ovf     (ovf),
    .zero    (zero),
    .max     (max)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic       ld, en, up, sat;
    logic [2:0] step;
    logic [4:0] din;
    logic       clr;
    logic [4:0] e_out;
    logic       e_tc, e_ovf;
  } vec_t;

  vec_t vt[23];

  function automatic vec_t mk(int ld, int en_i, int up, int sa, int stp, int din,
                              int clr, int eo, int et, int ev);
    vec_t v;
    v.ld    = ld[0];
    v.en    = en_i[0];
    v.up    = up[0];
    v.sat   = sa[0];
    v.step  = 3'(stp);
    v.din   = 5'(din);
    v.clr   = clr[0];
    v.e_out = 5'(eo);
    v.e_tc  = et[0];
    v.e_ovf = ev[0];
    return v;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s step%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(int idx, int eo, int et, int ev);
    chk("out", idx, int'(out), eo);
    chk("tc", idx, int'(tc), et);
    chk("ovf", idx, int'(ovf), ev);
    chk("zero", idx, int'(zero), (eo == 0) ? 1 : 0);
    chk("max", idx, int'(max), (eo == 23) ? 1 : 0);
  endtask

  task automatic apply(int i);
    load     = vt[i].ld;
    en       = vt[i].en;
    UpDown   = vt[i].up;
    sat      = vt[i].sat;
    step     = vt[i].step;
    in       = vt[i].din;
    clr_flag = vt[i].clr;
    @(posedge ck);
    #1;
    chk_all(i, int'(vt[i].e_out), int'(vt[i].e_tc), int'(vt[i].e_ovf));
  endtask

  initial begin
    //              ld en up sa st in clr  out tc ovf
    vt[0]  = mk(1, 0, 1, 0, 0, 20, 0, 20, 0, 0);
    vt[1]  = mk(0, 1, 1, 0, 7,  0, 0,  3, 1, 1);
    vt[2]  = mk(0, 1, 1, 0, 5,  0, 0,  8, 0, 1);
    vt[3]  = mk(0, 1, 1, 0, 5,  0, 0, 13, 0, 1);
    // after the mid-cycle reset: out=0, ovf=0
    vt[4]  = mk(1, 1, 1, 0, 3, 22, 0, 22, 0, 0);
    vt[5]  = mk(0, 1, 1, 0, 3,  0, 0,  1, 1, 1);
    vt[6]  = mk(0, 1, 1, 0, 1,  0, 0,  2, 0, 1);
    vt[7]  = mk(0, 1, 0, 1, 3,  0, 0,  0, 1, 1);
    vt[8]  = mk(0, 1, 0, 1, 3,  0, 0,  0, 1, 1);
    vt[9]  = mk(0, 1, 0, 1, 3,  0, 0,  0, 1, 1);
    vt[10] = mk(0, 0, 0, 0, 0,  0, 1,  0, 0, 0);
    vt[11] = mk(1, 0, 1, 0, 0, 30, 0, 23, 0, 1);
    vt[12] = mk(0, 1, 1, 0, 1,  0, 1,  0, 1, 1);
    vt[13] = mk(0, 0, 1, 0, 0,  0, 1,  0, 0, 0);
    vt[14] = mk(0, 1, 0, 0, 5,  0, 0, 19, 1, 1);
    vt[15] = mk(0, 1, 1, 1, 7,  0, 0, 23, 1, 1);
    vt[16] = mk(0, 1, 1, 1, 7,  0, 0, 23, 1, 1);
    vt[17] = mk(0, 1, 1, 0, 0,  0, 0, 23, 0, 1);
    vt[18] = mk(0, 1, 0, 0, 0,  0, 0, 23, 0, 1);
    vt[19] = mk(0, 0, 1, 0, 0,  0, 1, 23, 0, 0);
    vt[20] = mk(1, 0, 1, 0, 0, 23, 0, 23, 0, 0);
    vt[21] = mk(1, 0, 1, 0, 0, 24, 0, 23, 0, 1);
    vt[22] = mk(0, 1, 0, 1, 7,  0, 0, 16, 0, 1);

    reset = 1'b0; load = 1'b0; en = 1'b0; UpDown = 1'b1; sat = 1'b0;
    step = '0; in = '0; clr_flag = 1'b0;
    #1 reset = 1'b1;
    #1 chk_all(-1, 0, 0, 0);
    @(negedge ck);
    reset = 1'b0;

    for (int i = 0; i <= 3; i++) apply(i);

    // Asynchronous reset between edges, observed before the next edge.
    reset = 1'b1;
    #1 chk_all(100, 0, 0, 0);
    #1 reset = 1'b0;

    for (int i = 4; i <= 22; i++) apply(i);

    // Disabled counter ignores step/direction/mode churn.
    load = 1'b0; en = 1'b0; clr_flag = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step   = 3'($urandom_range(7, 0));
      UpDown = 1'($urandom_range(1, 0));
      sat    = 1'($urandom_range(1, 0));
      @(posedge ck);
      #1;
      chk("hold_out", 200 + k, int'(out), 16);
      chk("hold_tc", 200 + k, int'(tc), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
